// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_arbiter
// Description : 8-digit multiplexed seven-segment display driver. Shows a
//               default word (memory or debug) and lets queued processor
//               store events take over the display for a fixed number of
//               scan frames each.
//               Optional feature macro: DISP_LZ_BLANK_EN (leading-zero
//               blanking of the default word while idle).
// Revision    : 1.0 - initial release
// ============================================================================
module disp_arbiter #(
    parameter int SCAN_DIV    = 262144,
    parameter int HOLD_FRAMES = 48
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        show_i,
    input  logic [31:0] mem_data_i,
    input  logic [31:0] dbg_data_i,
    input  logic        evt_valid_i,
    input  logic [31:0] evt_addr_i,
    input  logic [31:0] evt_wdata_i,
    output logic        evt_ready_o,
    output logic [6:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        busy_o,
    output logic        ovf_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Cathode pattern for one hex nibble, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_q;
    logic          tick_q;
    logic [2:0]    idx_q;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    state_t        state_q;
    logic [FW-1:0] frames_q;
    logic          ovf_q;
    logic [31:0]   fifo_q [4];
    logic [1:0]    wr_ptr_q;
    logic [1:0]    rd_ptr_q;
    logic [2:0]    count_q;
    logic [2:0]    count_d;

    logic          push;
    logic          pop;
    logic          frame_end;
    logic [31:0]   entry;
    logic [31:0]   disp_word;
    logic [3:0]    nibble;
    logic          blank;
    logic          unused_bits;

    // Only the word-address and low data half of a store are displayed.
    assign unused_bits = ^{evt_addr_i[31:10], evt_addr_i[1:0], evt_wdata_i[31:16]};

    assign evt_ready_o = (count_q != 3'd4);
    assign push        = evt_valid_i && evt_ready_o;
    assign frame_end   = tick_q && (idx_q == 3'd7);
    assign pop         = (state_q == ST_SHOW) && frame_end && (frames_q == FW'(1));
    assign count_d     = count_q + {2'b00, push} - {2'b00, pop};
    assign entry       = {8'hEE, evt_addr_i[9:2], evt_wdata_i[15:0]};
    assign disp_word   = (state_q == ST_SHOW) ? fifo_q[rd_ptr_q]
                                              : (show_i ? mem_data_i : dbg_data_i);
    assign nibble      = disp_word[{idx_q, 2'b00} +: 4];

`ifdef DISP_LZ_BLANK_EN
    logic [2:0] lz_msn;

    // Position of the most-significant nonzero nibble (0 when the word is 0).
    always_comb begin
        lz_msn = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (disp_word[4*i +: 4] != 4'h0) begin
                lz_msn = 3'(i);
            end
        end
    end

    assign blank = (state_q == ST_IDLE) && (idx_q > lz_msn);
`else
    assign blank = 1'b0;
`endif

    // Prescaler: free-running 0..SCAN_DIV-1, registered one-clk tick at the top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == CW'(SCAN_DIV - 1));
            if (cnt_q == CW'(SCAN_DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Digit scan: on each tick strobe the current digit and step the index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= 3'd0;
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
        end else if (tick_q) begin
            idx_q <= idx_q + 3'd1;
            an_q  <= ~(8'h01 << idx_q);
            seg_q <= blank ? 7'h7F : hex_to_seg(nibble);
        end
    end

    // Event FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= entry;
        end
    end

    // Event FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
            if (evt_valid_i && !evt_ready_o) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Display arbitration FSM: default source vs. queued event for HOLD_FRAMES.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            frames_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != 3'd0) begin
                        state_q  <= ST_SHOW;
                        frames_q <= FW'(HOLD_FRAMES);
                    end
                end
                ST_SHOW: begin
                    if (frame_end) begin
                        if (frames_q == FW'(1)) begin
                            // Head is popped now; keep showing if anything remains.
                            if (count_d != 3'd0) begin
                                frames_q <= FW'(HOLD_FRAMES);
                            end else begin
                                state_q  <= ST_IDLE;
                                frames_q <= '0;
                            end
                        end else begin
                            frames_q <= frames_q - FW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    frames_q <= '0;
                end
            endcase
        end
    end

    assign seg_o  = seg_q;
    assign an_o   = an_q;
    assign busy_o = (state_q == ST_SHOW);
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire
